// File: rtl/snake_collision_detector_pkg.sv
// Shared types for the snake game logic: move directions, FSM states and
// the helper that finds the 180-degree opposite of a heading.
package snake_collision_detector_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    UPDATE,
    DEAD
  } state_t;

  // Opposite headings differ only in bit 1 (UP<->DOWN, RIGHT<->LEFT).
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_collision_detector_if.sv
// Game-side bundle of the collision detector: tick/direction/apple inputs,
// occupancy query and the event/status outputs for score and display.
interface snake_collision_detector_if #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int MAX_LEN = 16
);
  import snake_collision_detector_pkg::*;

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          moveTick;
  dir_t          dir;
  logic [XW-1:0] appleX;
  logic [YW-1:0] appleY;
  logic          restart;
  logic          gameComplete;
  logic [XW-1:0] qX;
  logic [YW-1:0] qY;
  logic          qHit;
  logic          goodColl;
  logic          badColl;
  logic [XW-1:0] headX;
  logic [YW-1:0] headY;
  logic [LW-1:0] snakeLen;
  logic          isDead;

  // Player/timer side.
  modport master (
    output moveTick, dir, appleX, appleY, restart, gameComplete, qX, qY,
    input  qHit, goodColl, badColl, headX, headY, snakeLen, isDead
  );

  // Collision detector side.
  modport slave (
    input  moveTick, dir, appleX, appleY, restart, gameComplete, qX, qY,
    output qHit, goodColl, badColl, headX, headY, snakeLen, isDead
  );

endinterface

// File: rtl/snake_collision_detector_next_head.sv
// Next head cell for one step in the given heading, plus the wall flag.
// The wall test looks at the untruncated step, so moving off an edge never
// wraps to the opposite side.
module snake_next_head
  import snake_collision_detector_pkg::*;
#(
  parameter int   GRID_W = 8,
  parameter int   GRID_H = 8,
  localparam int  XW     = $clog2(GRID_W),
  localparam int  YW     = $clog2(GRID_H)
) (
  input  logic [XW-1:0] headX,
  input  logic [YW-1:0] headY,
  input  dir_t          effDir,
  output logic [XW-1:0] nextX,
  output logic [YW-1:0] nextY,
  output logic          wallHit
);

  // Step one cell; UP decreases the row index (screen coordinates).
  always_comb begin
    nextX   = headX;
    nextY   = headY;
    wallHit = 1'b0;
    case (effDir)
      UP: begin
        wallHit = (headY == '0);
        nextY   = headY - YW'(1);
      end
      DOWN: begin
        wallHit = (headY == YW'(GRID_H - 1));
        nextY   = headY + YW'(1);
      end
      LEFT: begin
        wallHit = (headX == '0);
        nextX   = headX - XW'(1);
      end
      RIGHT: begin
        wallHit = (headX == XW'(GRID_W - 1));
        nextX   = headX + XW'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_collision_detector.sv
// Snake body tracker and collision event source for score_tracker.
// A moveTick in IDLE latches the heading; CHECK evaluates wall/self/apple
// against the candidate head and commits the move; the pulse is visible
// during UPDATE, two cycles after the tick.
module snake_collision_detector
  import snake_collision_detector_pkg::*;
#(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       nRst,
  snake_collision_detector_if.slave  bus
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [XW-1:0] X0 = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y0 = YW'(GRID_H / 2);

  state_t                    state;
  dir_t                      curDir, effDir, tickDir;
  logic [MAX_LEN-1:0][XW-1:0] segX;
  logic [MAX_LEN-1:0][YW-1:0] segY;
  logic [LW-1:0]             snakeLen;
  logic                      goodQ, badQ, isDeadQ;
  logic [XW-1:0]             nextX;
  logic [YW-1:0]             nextY;
  logic                      wallHit, eat, selfHit, qHit;

  snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next_head (
    .headX   (segX[0]),
    .headY   (segY[0]),
    .effDir  (effDir),
    .nextX   (nextX),
    .nextY   (nextY),
    .wallHit (wallHit)
  );

  assign eat = (nextX == bus.appleX) && (nextY == bus.appleY);

  // A multi-segment snake cannot fold back onto its own neck.
  assign tickDir = (snakeLen > LW'(1) && bus.dir == opposite(curDir)) ? curDir : bus.dir;

  // Body collision; the tail slot moves away this step unless we grow.
  always_comb begin
    selfHit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < snakeLen && (eat || LW'(i) != snakeLen - LW'(1)) &&
          segX[i] == nextX && segY[i] == nextY)
        selfHit = 1'b1;
    end
  end

  // Display occupancy lookup over live segments.
  always_comb begin
    qHit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < snakeLen && segX[i] == bus.qX && segY[i] == bus.qY)
        qHit = 1'b1;
    end
  end

  // Game FSM; gameComplete overrides every state and decision.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      curDir   <= RIGHT;
      effDir   <= RIGHT;
      snakeLen <= LW'(1);
      goodQ    <= 1'b0;
      badQ     <= 1'b0;
      isDeadQ  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        segX[i] <= X0;
        segY[i] <= Y0;
      end
    end else begin
      goodQ <= 1'b0;
      badQ  <= 1'b0;
      if (bus.gameComplete) begin
        state   <= DEAD;
        isDeadQ <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.moveTick) begin
              effDir <= tickDir;
              state  <= CHECK;
            end
          end
          CHECK: begin
            state <= UPDATE;
            if (wallHit || selfHit) begin
              badQ <= 1'b1;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                segX[i] <= segX[i-1];
                segY[i] <= segY[i-1];
              end
              segX[0] <= nextX;
              segY[0] <= nextY;
              curDir  <= effDir;
              if (eat) begin
                goodQ <= 1'b1;
                if (snakeLen != LW'(MAX_LEN))
                  snakeLen <= snakeLen + LW'(1);
              end
            end
          end
          UPDATE: begin
            state   <= badQ ? DEAD : IDLE;
            isDeadQ <= badQ;
          end
          DEAD: begin
            if (bus.restart) begin
              state    <= IDLE;
              curDir   <= RIGHT;
              effDir   <= RIGHT;
              snakeLen <= LW'(1);
              isDeadQ  <= 1'b0;
              for (int i = 0; i < MAX_LEN; i++) begin
                segX[i] <= X0;
                segY[i] <= Y0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A game completing in the pulse cycle swallows the pulse.
  assign bus.goodColl = goodQ & ~bus.gameComplete;
  assign bus.badColl  = badQ  & ~bus.gameComplete;
  assign bus.headX    = segX[0];
  assign bus.headY    = segY[0];
  assign bus.snakeLen = snakeLen;
  assign bus.isDead   = isDeadQ;
  assign bus.qHit     = qHit;

endmodule

// File: tb/tb_snake_collision_detector.sv
// Scenario bench for snake_collision_detector: each move pushes its expected
// pulse/head/length/dead state onto a scoreboard, which is popped when the
// move's response window is sampled.
module tb_snake_collision_detector;
  import snake_collision_detector_pkg::*;

  typedef struct packed {
    logic       good;
    logic       bad;
    logic [2:0] hx;
    logic [2:0] hy;
    logic [4:0] len;
    logic       dead;
  } obs_t;

  typedef struct {
    dir_t       d;
    logic [2:0] ax;
    logic [2:0] ay;
    logic       gc;
  } stim_t;

  typedef struct {
    obs_t at;
    obs_t post;
  } exp_t;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  int   vec = 0;
  int   miss = 0;

  stim_t stim_q[$];
  exp_t  sb[$];

  always #5 clk = ~clk;

  snake_collision_detector_if #(.GRID_W(8), .GRID_H(8), .MAX_LEN(16)) bus ();

  snake_collision_detector #(.GRID_W(8), .GRID_H(8), .MAX_LEN(16)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  function automatic obs_t mk(bit g, bit b, int hx, int hy, int len, bit d);
    obs_t o;
    o.good = g; o.bad = b; o.hx = 3'(hx); o.hy = 3'(hy); o.len = 5'(len); o.dead = d;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.goodColl, bus.badColl, int'(bus.headX), int'(bus.headY),
              int'(bus.snakeLen), bus.isDead);
  endfunction

  // Queue a move and its expected response (pulse cycle, then one cycle later).
  function automatic void add(dir_t d, int ax, int ay, bit gc, bit g, bit b,
                              int hx, int hy, int len, bit dat, bit dp);
    stim_t s;
    exp_t  e;
    s.d = d; s.ax = 3'(ax); s.ay = 3'(ay); s.gc = gc;
    e.at   = mk(g, b, hx, hy, len, dat);
    e.post = mk(1'b0, 1'b0, hx, hy, len, dp);
    stim_q.push_back(s);
    sb.push_back(e);
  endfunction

  // One tick: sample the CHECK cycle, the pulse cycle and the cycle after.
  task automatic move(input stim_t s, output obs_t pre, output obs_t at, output obs_t post);
    bus.dir = s.d; bus.appleX = s.ax; bus.appleY = s.ay; bus.moveTick = 1'b1;
    @(negedge clk); bus.moveTick = 1'b0; pre = sample();
    @(negedge clk); if (s.gc) bus.gameComplete = 1'b1; #1; at = sample();
    @(negedge clk); bus.gameComplete = 1'b0; post = sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    nRst = 1'b0; repeat (3) @(negedge clk); nRst = 1'b1; @(negedge clk);
    o = sample();
    vec++; if (o !== mk(0, 0, 4, 4, 1, 0)) begin miss++; $display("FAIL reset_state got %b want %b", o, mk(0, 0, 4, 4, 1, 0)); end
    bus.qX = 3'd4; bus.qY = 3'd4; #1;
    vec++; if (bus.qHit !== 1'b1) begin miss++; $display("FAIL reset_qhit_head got %b want 1", bus.qHit); end
    bus.qX = 3'd0; bus.qY = 3'd0; #1;
    vec++; if (bus.qHit !== 1'b0) begin miss++; $display("FAIL reset_qhit_empty got %b want 0", bus.qHit); end
  endtask

  task automatic test_restart(input int ox, input int oy);
    obs_t o;
    bus.restart = 1'b1; @(negedge clk); bus.restart = 1'b0;
    o = sample();
    vec++; if (o !== mk(0, 0, 4, 4, 1, 0)) begin miss++; $display("FAIL restart_state got %b want %b", o, mk(0, 0, 4, 4, 1, 0)); end
    bus.qX = 3'(ox); bus.qY = 3'(oy); #1;
    vec++; if (bus.qHit !== 1'b0) begin miss++; $display("FAIL restart_qhit_old got %b want 0", bus.qHit); end
  endtask

  task automatic test_eat();
    stim_t s; exp_t e; obs_t pre, at, post, o;
    add(RIGHT, 5, 4, 0, 1, 0, 5, 4, 2, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); move(s, pre, at, post); e = sb.pop_front();
      vec++; if ({pre.good, pre.bad} !== 2'b00) begin miss++; $display("FAIL eat_early got %b want 00", {pre.good, pre.bad}); end
      vec++; if (at !== e.at) begin miss++; $display("FAIL eat_pulse got %b want %b", at, e.at); end
      vec++; if (post !== e.post) begin miss++; $display("FAIL eat_after got %b want %b", post, e.post); end
    end
    bus.qX = 3'd4; bus.qY = 3'd4; #1;
    vec++; if (bus.qHit !== 1'b1) begin miss++; $display("FAIL eat_qhit_body got %b want 1", bus.qHit); end
    bus.appleX = 3'd0; bus.appleY = 3'd0;
    bus.restart = 1'b1; @(negedge clk); bus.restart = 1'b0; @(negedge clk);
    o = sample();
    vec++; if (o !== mk(0, 0, 5, 4, 2, 0)) begin miss++; $display("FAIL restart_in_idle got %b want %b", o, mk(0, 0, 5, 4, 2, 0)); end
  endtask

  task automatic test_reverse_wall();
    stim_t s; exp_t e; obs_t pre, at, post;
    add(LEFT,  0, 0, 0, 0, 0, 6, 4, 2, 0, 0);
    add(RIGHT, 0, 0, 0, 0, 0, 7, 4, 2, 0, 0);
    add(RIGHT, 0, 0, 0, 0, 1, 7, 4, 2, 0, 1);
    add(RIGHT, 0, 0, 0, 0, 0, 7, 4, 2, 1, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); move(s, pre, at, post); e = sb.pop_front();
      vec++; if ({pre.good, pre.bad} !== 2'b00) begin miss++; $display("FAIL reverse_early got %b want 00", {pre.good, pre.bad}); end
      vec++; if (at !== e.at) begin miss++; $display("FAIL reverse_pulse got %b want %b", at, e.at); end
      vec++; if (post !== e.post) begin miss++; $display("FAIL reverse_after got %b want %b", post, e.post); end
    end
  endtask

  task automatic test_wall();
    stim_t s; exp_t e; obs_t pre, at, post;
    add(RIGHT, 0, 0, 0, 0, 0, 5, 4, 1, 0, 0);
    add(RIGHT, 0, 0, 0, 0, 0, 6, 4, 1, 0, 0);
    add(RIGHT, 0, 0, 0, 0, 0, 7, 4, 1, 0, 0);
    add(RIGHT, 0, 0, 0, 0, 1, 7, 4, 1, 0, 1);
    add(RIGHT, 0, 0, 0, 0, 0, 7, 4, 1, 1, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); move(s, pre, at, post); e = sb.pop_front();
      vec++; if ({pre.good, pre.bad} !== 2'b00) begin miss++; $display("FAIL wall_early got %b want 00", {pre.good, pre.bad}); end
      vec++; if (at !== e.at) begin miss++; $display("FAIL wall_pulse got %b want %b", at, e.at); end
      vec++; if (post !== e.post) begin miss++; $display("FAIL wall_after got %b want %b", post, e.post); end
    end
  endtask

  task automatic test_self_hit();
    stim_t s; exp_t e; obs_t pre, at, post;
    add(LEFT,  0, 0, 0, 0, 0, 3, 4, 1, 0, 0);
    add(LEFT,  0, 0, 0, 0, 0, 2, 4, 1, 0, 0);
    add(LEFT,  0, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    add(RIGHT, 2, 4, 0, 1, 0, 2, 4, 2, 0, 0);
    add(RIGHT, 3, 4, 0, 1, 0, 3, 4, 3, 0, 0);
    add(RIGHT, 4, 4, 0, 1, 0, 4, 4, 4, 0, 0);
    add(RIGHT, 5, 4, 0, 1, 0, 5, 4, 5, 0, 0);
    add(RIGHT, 6, 4, 0, 1, 0, 6, 4, 6, 0, 0);
    add(UP,    0, 0, 0, 0, 0, 6, 3, 6, 0, 0);
    add(LEFT,  0, 0, 0, 0, 0, 5, 3, 6, 0, 0);
    add(DOWN,  5, 4, 0, 0, 1, 5, 3, 6, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); move(s, pre, at, post); e = sb.pop_front();
      vec++; if ({pre.good, pre.bad} !== 2'b00) begin miss++; $display("FAIL self_early got %b want 00", {pre.good, pre.bad}); end
      vec++; if (at !== e.at) begin miss++; $display("FAIL self_pulse got %b want %b", at, e.at); end
      vec++; if (post !== e.post) begin miss++; $display("FAIL self_after got %b want %b", post, e.post); end
    end
  endtask

  task automatic test_tail_chase();
    stim_t s; exp_t e; obs_t pre, at, post;
    add(RIGHT, 5, 4, 0, 1, 0, 5, 4, 2, 0, 0);
    add(UP,    5, 3, 0, 1, 0, 5, 3, 3, 0, 0);
    add(LEFT,  4, 3, 0, 1, 0, 4, 3, 4, 0, 0);
    add(DOWN,  0, 0, 0, 0, 0, 4, 4, 4, 0, 0);
    add(RIGHT, 0, 0, 0, 0, 0, 5, 4, 4, 0, 0);
    add(UP,    0, 0, 0, 0, 0, 5, 3, 4, 0, 0);
    add(LEFT,  0, 0, 0, 0, 0, 4, 3, 4, 0, 0);
    add(DOWN,  4, 4, 0, 0, 1, 4, 3, 4, 0, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); move(s, pre, at, post); e = sb.pop_front();
      vec++; if ({pre.good, pre.bad} !== 2'b00) begin miss++; $display("FAIL tail_early got %b want 00", {pre.good, pre.bad}); end
      vec++; if (at !== e.at) begin miss++; $display("FAIL tail_pulse got %b want %b", at, e.at); end
      vec++; if (post !== e.post) begin miss++; $display("FAIL tail_after got %b want %b", post, e.post); end
    end
  endtask

  task automatic test_game_complete();
    stim_t s; exp_t e; obs_t pre, at, post;
    add(RIGHT, 5, 4, 1, 0, 0, 5, 4, 2, 0, 1);
    add(RIGHT, 0, 0, 0, 0, 0, 5, 4, 2, 1, 1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); move(s, pre, at, post); e = sb.pop_front();
      vec++; if ({pre.good, pre.bad} !== 2'b00) begin miss++; $display("FAIL gc_early got %b want 00", {pre.good, pre.bad}); end
      vec++; if (at !== e.at) begin miss++; $display("FAIL gc_pulse got %b want %b", at, e.at); end
      vec++; if (post !== e.post) begin miss++; $display("FAIL gc_after got %b want %b", post, e.post); end
    end
  endtask

  initial begin
    bus.moveTick = 1'b0; bus.dir = RIGHT; bus.appleX = 3'd0; bus.appleY = 3'd0;
    bus.restart = 1'b0; bus.gameComplete = 1'b0; bus.qX = 3'd0; bus.qY = 3'd0;
    test_reset();
    test_eat();
    test_reverse_wall();
    test_restart(7, 4);
    test_wall();
    test_restart(7, 4);
    test_self_hit();
    test_restart(6, 4);
    test_tail_chase();
    test_restart(5, 3);
    test_game_complete();
    test_restart(5, 4);
    if (sb.size() != 0) begin
      vec++; miss++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
